vec_lsu_addr_gen: RTL and testbench

VEC_LSU_ADDR_GEN -- requirements
Module: vec_lsu_addr_gen

---
 rtl/vec_lsu_addr_gen_pkg.sv | 33 +++
 rtl/vec_lsu_lane_align.sv | 41 ++++
 rtl/vec_lsu_addr_gen.sv | 216 +++++++++++++++++++++
 tb/tb_vec_lsu_addr_gen.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_lsu_addr_gen_pkg.sv
// Shared definitions for the vector LSU address generator: FSM states and element-width encoding.
package vector_processor_defs;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ISSUE    = 2'b01,
        WAIT_RSP = 2'b10,
        FINISH   = 2'b11
    } lsu_state_e;

    localparam logic [1:0] EEW_8    = 2'b00;
    localparam logic [1:0] EEW_16   = 2'b01;
    localparam logic [1:0] EEW_32   = 2'b10;
    localparam logic [1:0] EEW_RSVD = 2'b11;

    // log2 of the element size in bytes; the reserved encoding behaves as 32b
    function automatic logic [1:0] eew_lg(input logic [1:0] eew);
        case (eew)
            EEW_8:   return 2'd0;
            EEW_16:  return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] eew_align_mask(input logic [1:0] eew);
        case (eew)
            EEW_8:   return 2'b00;
            EEW_16:  return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/vec_lsu_lane_align.sv
// Byte-lane steering for the LSU: request byte enables and store data, load data extraction.
module vec_lsu_lane_align
    import vector_processor_defs::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      eew,
    input  logic [1:0]      req_addr_lo,
    input  logic [XLEN-1:0] st_data,
    input  logic [1:0]      rsp_addr_lo,
    input  logic [XLEN-1:0] rsp_data,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    logic [3:0]      be_base;
    logic [XLEN-1:0] rsp_shifted;

    always_comb begin
        case (eew)
            EEW_8:   be_base = 4'b0001;
            EEW_16:  be_base = 4'b0011;
            default: be_base = 4'b1111;
        endcase
    end

    assign be          = be_base << req_addr_lo;
    assign wdata       = st_data << {req_addr_lo, 3'b000};
    assign rsp_shifted = rsp_data >> {rsp_addr_lo, 3'b000};

    always_comb begin
        rdata = '0;
        case (eew)
            EEW_8:   rdata[7:0]  = rsp_shifted[7:0];
            EEW_16:  rdata[15:0] = rsp_shifted[15:0];
            default: rdata[31:0] = rsp_shifted[31:0];
        endcase
    end

endmodule

// File: rtl/vec_lsu_addr_gen.sv
// Vector LSU address generator: one outstanding request per element for unit-stride, strided
// and indexed loads/stores. Define VEC_LSU_MISALIGN_CHK_EN for the alignment check and err port.
module vec_lsu_addr_gen
    import vector_processor_defs::*;
#(
    parameter int unsigned  XLEN   = 32,
    parameter int unsigned  MAX_VL = 64,
    localparam int unsigned VLW    = $clog2(MAX_VL) + 1,
    localparam int unsigned EW     = $clog2(MAX_VL)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            ld_inst,
    input  logic            st_inst,
    input  logic            stride_sel,
    input  logic            index_str,
    input  logic            index_unordered,
    input  logic [XLEN-1:0] base_addr,
    input  logic [XLEN-1:0] stride,
    input  logic [VLW-1:0]  vl,
    input  logic [1:0]      eew,
    output logic [EW-1:0]   elem_idx,
    input  logic [XLEN-1:0] idx_offset,
    input  logic [XLEN-1:0] st_elem_data,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            ld_wr_en,
    output logic [EW-1:0]   ld_wr_idx,
    output logic [XLEN-1:0] ld_wr_data,
    output logic            busy,
`ifdef VEC_LSU_MISALIGN_CHK_EN
    output logic            err,
`endif
    output logic            done
);

    lsu_state_e      state_q, state_d;
    logic [EW-1:0]   elem_q, elem_d;
    logic [XLEN-1:0] base_q, base_d, stride_q, stride_d, acc_q, acc_d;
    logic [VLW-1:0]  vl_q, vl_d;
    logic [1:0]      eew_q, eew_d, addr_lo_q, addr_lo_d;
    logic            st_q, st_d, unit_q, unit_d, index_q, index_d;
    logic            ld_wr_en_q, ld_wr_en_d;
    logic [EW-1:0]   ld_wr_idx_q, ld_wr_idx_d;
    logic [XLEN-1:0] ld_wr_data_q, ld_wr_data_d;
    logic [XLEN-1:0] off_ext, cur_addr, step, rdata, wdata;
    logic [3:0]      be;
    logic            issue, req_ok;
    logic            unused_inputs;
`ifdef VEC_LSU_MISALIGN_CHK_EN
    logic            err_q, err_d, misalign;
`endif

    // Both indexed orderings are served in element order, so the flag needs no handling.
    assign unused_inputs = index_unordered;

    always_comb begin
        off_ext = '0;
        case (eew_q)
            EEW_8:   off_ext[7:0]  = idx_offset[7:0];
            EEW_16:  off_ext[15:0] = idx_offset[15:0];
            default: off_ext[31:0] = idx_offset[31:0];
        endcase
    end

    assign cur_addr = index_q ? base_q + off_ext : acc_q;
    assign step     = unit_q ? (XLEN'(1) << eew_lg(eew_q)) : stride_q;
    assign issue    = (state_q == ISSUE);

`ifdef VEC_LSU_MISALIGN_CHK_EN
    assign misalign = |(cur_addr[1:0] & eew_align_mask(eew_q));
    assign req_ok   = issue && !misalign;
    assign err      = err_q;
`else
    assign req_ok   = issue;
`endif

    vec_lsu_lane_align #(.XLEN(XLEN)) u_lane_align (
        .eew         (eew_q),
        .req_addr_lo (cur_addr[1:0]),
        .st_data     (st_elem_data),
        .rsp_addr_lo (addr_lo_q),
        .rsp_data    (mem_rsp_data),
        .be          (be),
        .wdata       (wdata),
        .rdata       (rdata)
    );

    assign mem_req_valid = req_ok;
    assign mem_addr      = issue ? cur_addr : '0;
    assign mem_be        = issue ? be : '0;
    assign mem_wdata     = issue ? wdata : '0;
    assign mem_we        = st_q;
    assign elem_idx      = elem_q;
    assign ld_wr_en      = ld_wr_en_q;
    assign ld_wr_idx     = ld_wr_idx_q;
    assign ld_wr_data    = ld_wr_data_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == FINISH);

    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        base_d       = base_q;
        stride_d     = stride_q;
        acc_d        = acc_q;
        vl_d         = vl_q;
        eew_d        = eew_q;
        addr_lo_d    = addr_lo_q;
        st_d         = st_q;
        unit_d       = unit_q;
        index_d      = index_q;
        ld_wr_en_d   = 1'b0;
        ld_wr_idx_d  = ld_wr_idx_q;
        ld_wr_data_d = ld_wr_data_q;
`ifdef VEC_LSU_MISALIGN_CHK_EN
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && (ld_inst ^ st_inst)) begin
                    st_d     = st_inst;
                    unit_d   = stride_sel;
                    index_d  = index_str;
                    base_d   = base_addr;
                    stride_d = stride;
                    acc_d    = base_addr;
                    vl_d     = vl;
                    eew_d    = eew;
                    elem_d   = '0;
`ifdef VEC_LSU_MISALIGN_CHK_EN
                    err_d    = 1'b0;
`endif
                    state_d  = (vl == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
`ifdef VEC_LSU_MISALIGN_CHK_EN
                if (misalign) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else
`endif
                if (mem_req_ready) begin
                    addr_lo_d = cur_addr[1:0];
                    state_d   = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    if (!st_q) begin
                        ld_wr_en_d   = 1'b1;
                        ld_wr_idx_d  = elem_q;
                        ld_wr_data_d = rdata;
                    end
                    acc_d = acc_q + step;
                    if (VLW'(elem_q) == vl_q - VLW'(1)) begin
                        state_d = FINISH;
                    end else begin
                        elem_d  = elem_q + EW'(1);
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            elem_q       <= '0;
            base_q       <= '0;
            stride_q     <= '0;
            acc_q        <= '0;
            vl_q         <= '0;
            eew_q        <= '0;
            addr_lo_q    <= '0;
            st_q         <= 1'b0;
            unit_q       <= 1'b0;
            index_q      <= 1'b0;
            ld_wr_en_q   <= 1'b0;
            ld_wr_idx_q  <= '0;
            ld_wr_data_q <= '0;
`ifdef VEC_LSU_MISALIGN_CHK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            elem_q       <= elem_d;
            base_q       <= base_d;
            stride_q     <= stride_d;
            acc_q        <= acc_d;
            vl_q         <= vl_d;
            eew_q        <= eew_d;
            addr_lo_q    <= addr_lo_d;
            st_q         <= st_d;
            unit_q       <= unit_d;
            index_q      <= index_d;
            ld_wr_en_q   <= ld_wr_en_d;
            ld_wr_idx_q  <= ld_wr_idx_d;
            ld_wr_data_q <= ld_wr_data_d;
`ifdef VEC_LSU_MISALIGN_CHK_EN
            err_q        <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_vec_lsu_addr_gen.sv
// Scoreboard bench for vec_lsu_addr_gen: expected requests/load writes are queued at launch
// and compared as the DUT produces them. The err checks build only with VEC_LSU_MISALIGN_CHK_EN.
module tb_vec_lsu_addr_gen;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] data;
    } ldw_t;

    logic        clk, reset, start, ld_inst, st_inst, stride_sel, index_str, index_unordered;
    logic [31:0] base_addr, stride, idx_offset, st_elem_data, mem_addr, mem_wdata, ld_wr_data;
    logic [31:0] mem_rsp_data = '0;
    logic        mem_rsp_valid = 1'b0;
    logic [6:0]  vl;
    logic [1:0]  eew;
    logic [5:0]  elem_idx, ld_wr_idx;
    logic        mem_req_valid, mem_req_ready, mem_we, ld_wr_en, busy, done;
    logic [3:0]  mem_be;
`ifdef VEC_LSU_MISALIGN_CHK_EN
    logic        err;
`endif

    req_t        exp_req[$];
    ldw_t        exp_ld[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_ld[$];
    logic [31:0] offs[64];
    logic [31:0] st_mem[64];
    logic [31:0] rsp_word;
    logic        rsp_auto;
    logic        rsp_pending = 1'b0;
    int          n_checks = 0, n_fail = 0;
    int          req_cnt = 0, ld_cnt = 0, done_cnt = 0, d_base = 0;
    int          inj_req = 0, inj_seen = 0;

    vec_lsu_addr_gen #(.XLEN(32), .MAX_VL(64)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .ld_inst         (ld_inst),
        .st_inst         (st_inst),
        .stride_sel      (stride_sel),
        .index_str       (index_str),
        .index_unordered (index_unordered),
        .base_addr       (base_addr),
        .stride          (stride),
        .vl              (vl),
        .eew             (eew),
        .elem_idx        (elem_idx),
        .idx_offset      (idx_offset),
        .st_elem_data    (st_elem_data),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_addr        (mem_addr),
        .mem_we          (mem_we),
        .mem_be          (mem_be),
        .mem_wdata       (mem_wdata),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .ld_wr_en        (ld_wr_en),
        .ld_wr_idx       (ld_wr_idx),
        .ld_wr_data      (ld_wr_data),
        .busy            (busy),
`ifdef VEC_LSU_MISALIGN_CHK_EN
        .err             (err),
`endif
        .done            (done)
    );

    assign idx_offset   = offs[elem_idx];
    assign st_elem_data = st_mem[elem_idx];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] zext_e(input logic [31:0] v, input logic [1:0] e);
        case (e)
            2'b00:   return v & 32'h0000_00FF;
            2'b01:   return v & 32'h0000_FFFF;
            default: return v;
        endcase
    endfunction

    // Bus/responder process: everything sampled and driven at the falling edge.
    always @(negedge clk) begin
        req_t r;
        ldw_t w;
        if (inj_req != inj_seen) begin
            mem_rsp_valid = 1'b1;
            inj_seen++;
        end else if (rsp_pending) begin
            mem_rsp_valid = 1'b1;
            rsp_pending   = 1'b0;
        end else begin
            mem_rsp_valid = 1'b0;
        end
        mem_rsp_data = rsp_word;
        if (mem_req_valid && mem_req_ready) begin
            req_cnt++;
            obs_addr.push_back(mem_addr);
            rsp_pending = rsp_auto;
            if (exp_req.size() == 0) begin
                chk("req_expected", 32'(exp_req.size() != 0), 32'd1);
            end else begin
                r = exp_req.pop_front();
                chk("req_addr", mem_addr, r.addr);
                chk("req_we", 32'(mem_we), 32'(r.we));
                chk("req_be", 32'(mem_be), 32'(r.be));
                chk("req_wdata", mem_wdata, r.wdata);
            end
        end
        if (ld_wr_en) begin
            ld_cnt++;
            obs_ld.push_back(ld_wr_data);
            if (exp_ld.size() == 0) begin
                chk("ldw_expected", 32'(exp_ld.size() != 0), 32'd1);
            end else begin
                w = exp_ld.pop_front();
                chk("ldw_idx", 32'(ld_wr_idx), 32'(w.idx));
                chk("ldw_data", ld_wr_data, w.data);
            end
        end
        if (done) done_cnt++;
    end

    task automatic launch(input logic ld, input logic st, input logic ssel, input logic ix,
                          input logic [31:0] base, input logic [31:0] strd,
                          input int unsigned n, input logic [1:0] e, input logic no_exp);
        logic [31:0] a;
        logic [7:0]  bm;
        logic [1:0]  lo;
        int unsigned nb;
        nb = (e == 2'b00) ? 1 : (e == 2'b01) ? 2 : 4;
        if ((ld ^ st) && !no_exp) begin
            for (int unsigned i = 0; i < n; i++) begin
                if (ix)        a = base + zext_e(offs[i], e);
                else if (ssel) a = base + 32'(i * nb);
                else           a = base + 32'(i) * strd;
                lo = a[1:0];
                bm = 8'((1 << nb) - 1) << lo;
                exp_req.push_back('{addr: a, we: st, be: bm[3:0], wdata: st_mem[i] << (8 * lo)});
                if (ld) exp_ld.push_back('{idx: 6'(i), data: zext_e(rsp_word >> (8 * lo), e)});
            end
        end
        obs_addr.delete();
        obs_ld.delete();
        d_base     = done_cnt;
        ld_inst    = ld;
        st_inst    = st;
        stride_sel = ssel;
        index_str  = ix;
        base_addr  = base;
        stride     = strd;
        vl         = 7'(n);
        eew        = e;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int unsigned bound);
        for (int unsigned c = 0; c < bound; c++) begin
            if (done_cnt != d_base) break;
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        chk({tag, "_done_once"}, 32'(done_cnt - d_base), 32'd1);
        chk({tag, "_req_left"}, 32'(exp_req.size()), 32'd0);
        chk({tag, "_ldw_left"}, 32'(exp_ld.size()), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int r0, l0, d0;
        reset = 1'b1;
        start = 1'b0; ld_inst = 1'b0; st_inst = 1'b0; stride_sel = 1'b0;
        index_str = 1'b0; index_unordered = 1'b0;
        base_addr = '0; stride = '0; vl = '0; eew = '0;
        mem_req_ready = 1'b1;
        rsp_auto = 1'b1;
        rsp_word = 32'h1122_3344;
        for (int i = 0; i < 64; i++) begin
            offs[i]   = 32'(i * 4);
            st_mem[i] = 32'h0000_00A5 + 32'(i);
        end
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(mem_req_valid), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_be", 32'(mem_be), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ldw_en", 32'(ld_wr_en), 0);
        chk("rst_ldw_idx", 32'(ld_wr_idx), 0);
        chk("rst_ldw_data", ld_wr_data, 0);
        chk("rst_elem", 32'(elem_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
`ifdef VEC_LSU_MISALIGN_CHK_EN
        chk("rst_err", 32'(err), 0);
`endif
        reset = 1'b0;

        // unit-stride 32b load, start on the first edge after reset release
        l0 = ld_cnt;
        launch(1, 0, 1, 0, 32'h1000, 0, 4, 2'b10, 0);
        chk("ul_busy", 32'(busy), 1);
        wait_done("ul", 100);
        chk("ul_ldw_cnt", 32'(ld_cnt - l0), 4);
        chk("ul_addr3", obs_addr[3], 32'h100C);

        // strided byte store
        l0 = ld_cnt;
        launch(0, 1, 0, 0, 32'h2000, 32'h10, 3, 2'b00, 0);
        wait_done("ss", 100);
        chk("ss_ldw_cnt", 32'(ld_cnt - l0), 0);
        chk("ss_addr2", obs_addr[2], 32'h2020);

        // indexed halfword load, offset upper bits must be dropped
        offs[0] = 32'hFFFF_0006;
        offs[1] = 32'h0000_0002;
        rsp_word = 32'hAABB_CCDD;
        index_unordered = 1'b1;
        launch(1, 0, 0, 1, 32'h100, 0, 2, 2'b01, 0);
        wait_done("ix", 100);
        index_unordered = 1'b0;
        chk("ix_addr0", obs_addr[0], 32'h106);
        chk("ix_addr1", obs_addr[1], 32'h102);
        chk("ix_data0", obs_ld[0], 32'h0000_AABB);

        // vl == 0
        r0 = req_cnt;
        launch(1, 0, 1, 0, 32'h5000, 0, 0, 2'b10, 0);
        #4;
        chk("vl0_done", 32'(done), 1);
        chk("vl0_valid", 32'(mem_req_valid), 0);
        wait_done("vl0", 20);
        chk("vl0_reqs", 32'(req_cnt - r0), 0);

        // both ld_inst and st_inst: ignored
        r0 = req_cnt;
        d0 = done_cnt;
        launch(1, 1, 1, 0, 32'h6000, 0, 2, 2'b10, 0);
        chk("bad_start_busy", 32'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("bad_start_reqs", 32'(req_cnt - r0), 0);
        chk("bad_start_done", 32'(done_cnt - d0), 0);

        // ready held low with a start while busy
        rsp_word = 32'h1122_3344;
        mem_req_ready = 1'b0;
        r0 = req_cnt;
        launch(1, 0, 0, 0, 32'h3000, 32'h8, 2, 2'b10, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_addr", mem_addr, 32'h3000);
            chk("stall_valid", 32'(mem_req_valid), 1);
            if (k == 1) begin
                start = 1'b1; ld_inst = 1'b0; st_inst = 1'b1;
                base_addr = 32'hDEAD_0000; stride = 32'h40; vl = 7'd9;
            end
            if (k == 2) start = 1'b0;
        end
        mem_req_ready = 1'b1;
        wait_done("stall", 100);
        chk("stall_reqs", 32'(req_cnt - r0), 2);

        // reset while waiting for a response, then a late response
        rsp_auto = 1'b0;
        r0 = req_cnt;
        launch(1, 0, 1, 0, 32'h4000, 0, 2, 2'b10, 0);
        for (int c = 0; c < 20; c++) begin
            if (req_cnt != r0) break;
            @(posedge clk);
        end
        chk("rst_mid_handshake", 32'(req_cnt != r0), 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(mem_req_valid), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_done", 32'(done), 0);
        chk("rst_mid_addr", mem_addr, 0);
        chk("rst_mid_elem", 32'(elem_idx), 0);
        @(negedge clk);
        reset = 1'b0;
        l0 = ld_cnt;
        d0 = done_cnt;
        inj_req++;
        repeat (4) @(posedge clk);
        #1;
        chk("late_rsp_ldw", 32'(ld_cnt - l0), 0);
        chk("late_rsp_done", 32'(done_cnt - d0), 0);
        chk("late_rsp_busy", 32'(busy), 0);
        exp_req.delete();
        exp_ld.delete();
        rsp_auto = 1'b1;

`ifdef VEC_LSU_MISALIGN_CHK_EN
        // misaligned word access is refused with err
        r0 = req_cnt;
        launch(1, 0, 1, 0, 32'h1002, 0, 2, 2'b10, 1);
        #4;
        chk("mis_valid", 32'(mem_req_valid), 0);
        @(posedge clk);
        #4;
        chk("mis_done", 32'(done), 1);
        chk("mis_err", 32'(err), 1);
        wait_done("mis", 20);
        chk("mis_reqs", 32'(req_cnt - r0), 0);
        chk("mis_err_hold", 32'(err), 1);
        // halfword at the same address is aligned for its size
        launch(1, 0, 1, 0, 32'h1002, 0, 2, 2'b01, 0);
        chk("mis_err_clear", 32'(err), 0);
        wait_done("al16", 100);
        chk("al16_err", 32'(err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
